// File: rtl/dual_ad7528_attenuation.sv
// Gain stage modelling the two AD7528 multiplying DACs on the CD-i CDIC audio path.
// Define ATT_CROSSMIX_EN to enable the right->left and left->right cross-mix paths.
module dual_ad7528_attenuation (
    input  logic               clk,
    input  logic               reset,
    input  logic               datadac,
    input  logic               clkdac,
    input  logic               csdac1n,
    input  logic               csdac2n,
    input  logic signed [15:0] audio_left_in,
    input  logic signed [15:0] audio_right_in,
    output logic signed [15:0] audio_left_out,
    output logic signed [15:0] audio_right_out
);

    logic       r_clkdac_d;
    logic       r_cs1_d;
    logic       r_cs2_d;

    logic [8:0] r_sr1;
    logic [8:0] r_sr2;
    logic [3:0] r_cnt1;
    logic [3:0] r_cnt2;

    logic [7:0] r_gain_ll;
    logic [7:0] r_gain_rl;
    logic [7:0] r_gain_rr;
    logic [7:0] r_gain_lr;

    logic       w_clk_rise;
    logic       w_cs1_rise;
    logic       w_cs1_fall;
    logic       w_cs2_rise;
    logic       w_cs2_fall;
    logic       w_shift1;
    logic       w_shift2;
    logic [8:0] w_sr1_nxt;
    logic [8:0] w_sr2_nxt;
    logic [3:0] w_cnt1_base;
    logic [3:0] w_cnt2_base;
    logic [3:0] w_cnt1_nxt;
    logic [3:0] w_cnt2_nxt;
    logic       w_commit1;
    logic       w_commit2;

    assign w_clk_rise = clkdac & ~r_clkdac_d;
    assign w_cs1_rise = csdac1n & ~r_cs1_d;
    assign w_cs1_fall = ~csdac1n & r_cs1_d;
    assign w_cs2_rise = csdac2n & ~r_cs2_d;
    assign w_cs2_fall = ~csdac2n & r_cs2_d;

    // A clock edge seen together with the cs rising edge still belongs to the frame.
    assign w_shift1 = w_clk_rise & (~csdac1n | w_cs1_rise);
    assign w_shift2 = w_clk_rise & (~csdac2n | w_cs2_rise);

    always_comb begin
        w_sr1_nxt   = r_sr1;
        w_sr2_nxt   = r_sr2;
        w_cnt1_base = w_cs1_fall ? 4'd0 : r_cnt1;
        w_cnt2_base = w_cs2_fall ? 4'd0 : r_cnt2;
        w_cnt1_nxt  = w_cnt1_base;
        w_cnt2_nxt  = w_cnt2_base;
        if (w_shift1) begin
            w_sr1_nxt = {r_sr1[7:0], datadac};
            if (w_cnt1_base != 4'd15) begin
                w_cnt1_nxt = w_cnt1_base + 4'd1;
            end
        end
        if (w_shift2) begin
            w_sr2_nxt = {r_sr2[7:0], datadac};
            if (w_cnt2_base != 4'd15) begin
                w_cnt2_nxt = w_cnt2_base + 4'd1;
            end
        end
    end

    assign w_commit1 = w_cs1_rise && (w_cnt1_nxt >= 4'd9);
    assign w_commit2 = w_cs2_rise && (w_cnt2_nxt >= 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkdac_d <= 1'b0;
            r_cs1_d    <= 1'b1;
            r_cs2_d    <= 1'b1;
            r_sr1      <= 9'd0;
            r_sr2      <= 9'd0;
            r_cnt1     <= 4'd0;
            r_cnt2     <= 4'd0;
        end else begin
            r_clkdac_d <= clkdac;
            r_cs1_d    <= csdac1n;
            r_cs2_d    <= csdac2n;
            r_sr1      <= w_sr1_nxt;
            r_sr2      <= w_sr2_nxt;
            r_cnt1     <= w_cs1_rise ? 4'd0 : w_cnt1_nxt;
            r_cnt2     <= w_cs2_rise ? 4'd0 : w_cnt2_nxt;
        end
    end

    // Bit 8 of a frame selects DAC B; chip 1 drives the left output, chip 2 the right.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gain_ll <= 8'h00;
            r_gain_rl <= 8'h00;
            r_gain_rr <= 8'h00;
            r_gain_lr <= 8'h00;
        end else begin
            if (w_commit1) begin
                if (w_sr1_nxt[8]) begin
                    r_gain_rl <= w_sr1_nxt[7:0];
                end else begin
                    r_gain_ll <= w_sr1_nxt[7:0];
                end
            end
            if (w_commit2) begin
                if (w_sr2_nxt[8]) begin
                    r_gain_lr <= w_sr2_nxt[7:0];
                end else begin
                    r_gain_rr <= w_sr2_nxt[7:0];
                end
            end
        end
    end

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767) begin
            return 16'sh7fff;
        end else if (v < -26'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    logic signed [24:0] w_l25;
    logic signed [24:0] w_r25;
    logic signed [24:0] w_g_ll;
    logic signed [24:0] w_g_rr;

    // Products of a 16-bit signed sample and an 8-bit unsigned gain always fit in 25 bits.
    assign w_l25  = {{9{audio_left_in[15]}}, audio_left_in};
    assign w_r25  = {{9{audio_right_in[15]}}, audio_right_in};
    assign w_g_ll = {17'd0, r_gain_ll};
    assign w_g_rr = {17'd0, r_gain_rr};

    logic signed [24:0] r_p_ll;
    logic signed [24:0] r_p_rr;
    logic signed [25:0] w_sum_l;
    logic signed [25:0] w_sum_r;
    logic signed [25:0] w_shr_l;
    logic signed [25:0] w_shr_r;

`ifdef ATT_CROSSMIX_EN
    logic signed [24:0] w_g_rl;
    logic signed [24:0] w_g_lr;
    logic signed [24:0] r_p_rl;
    logic signed [24:0] r_p_lr;

    assign w_g_rl = {17'd0, r_gain_rl};
    assign w_g_lr = {17'd0, r_gain_lr};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_rl <= 25'sd0;
            r_p_lr <= 25'sd0;
        end else begin
            r_p_rl <= w_r25 * w_g_rl;
            r_p_lr <= w_l25 * w_g_lr;
        end
    end

    assign w_sum_l = {r_p_ll[24], r_p_ll} + {r_p_rl[24], r_p_rl};
    assign w_sum_r = {r_p_rr[24], r_p_rr} + {r_p_lr[24], r_p_lr};
`else
    // Cross gains are still programmable but do not reach the outputs in this build.
    logic w_unused_cross;
    assign w_unused_cross = ^{r_gain_rl, r_gain_lr};

    assign w_sum_l = {r_p_ll[24], r_p_ll};
    assign w_sum_r = {r_p_rr[24], r_p_rr};
`endif

    assign w_shr_l = w_sum_l >>> 8;
    assign w_shr_r = w_sum_r >>> 8;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_ll          <= 25'sd0;
            r_p_rr          <= 25'sd0;
            audio_left_out  <= 16'sd0;
            audio_right_out <= 16'sd0;
        end else begin
            r_p_ll          <= w_l25 * w_g_ll;
            r_p_rr          <= w_r25 * w_g_rr;
            audio_left_out  <= sat16(w_shr_l);
            audio_right_out <= sat16(w_shr_r);
        end
    end

endmodule

// File: tb/tb_dual_ad7528_attenuation.sv
// Self-checking bench for dual_ad7528_attenuation: directed test plan plus random frames,
// compared against a gain-table reference model (honours ATT_CROSSMIX_EN).
module tb_dual_ad7528_attenuation;

    logic               clk;
    logic               reset;
    logic               datadac;
    logic               clkdac;
    logic               csdac1n;
    logic               csdac2n;
    logic signed [15:0] audio_left_in;
    logic signed [15:0] audio_right_in;
    logic signed [15:0] audio_left_out;
    logic signed [15:0] audio_right_out;

    dual_ad7528_attenuation dut (
        .clk             (clk),
        .reset           (reset),
        .datadac         (datadac),
        .clkdac          (clkdac),
        .csdac1n         (csdac1n),
        .csdac2n         (csdac2n),
        .audio_left_in   (audio_left_in),
        .audio_right_in  (audio_right_in),
        .audio_left_out  (audio_left_out),
        .audio_right_out (audio_right_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ATT_CROSSMIX_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference gain table
    int g_ll, g_rl, g_rr, g_lr;
    int cur_l, cur_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mix(input int a, input int ga, input int b, input int gb);
        int v;
        v = a * ga + (CROSS ? b * gb : 0);
        v = v >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic int exp_left();
        return mix(cur_l, g_ll, cur_r, g_rl);
    endfunction

    function automatic int exp_right();
        return mix(cur_r, g_rr, cur_l, g_lr);
    endfunction

    task automatic model_frame(input bit c1, input bit c2, input logic [15:0] bits, input int n);
        int code;
        if (n >= 9) begin
            code = int'(bits[7:0]);
            if (c1) begin
                if (bits[8]) g_rl = code; else g_ll = code;
            end
            if (c2) begin
                if (bits[8]) g_lr = code; else g_rr = code;
            end
        end
    endtask

    // Sends the low n bits of 'bits' MSB first, then releases the chip selects.
    task automatic send_frame(input bit c1, input bit c2, input logic [15:0] bits, input int n);
        csdac1n = ~c1;
        csdac2n = ~c2;
        tick();
        for (int i = n - 1; i >= 0; i--) begin
            datadac = bits[i];
            clkdac  = 1'b1;
            tick();
            clkdac  = 1'b0;
            tick();
        end
        csdac1n = 1'b1;
        csdac2n = 1'b1;
        tick();
        tick();
        model_frame(c1, c2, bits, n);
    endtask

    task automatic hold_check(input string tag, input int l, input int r);
        logic [31:0] lv, rv;
        lv = l;
        rv = r;
        cur_l = l;
        cur_r = r;
        audio_left_in  = lv[15:0];
        audio_right_in = rv[15:0];
        repeat (3) tick();
        chk({tag, "_left"}, int'(audio_left_out), exp_left());
        chk({tag, "_right"}, int'(audio_right_out), exp_right());
    endtask

    initial begin
        logic [15:0] bits;
        int n, l, r;
        bit c1, c2;

        reset          = 1'b1;
        datadac        = 1'b0;
        clkdac         = 1'b0;
        csdac1n        = 1'b1;
        csdac2n        = 1'b1;
        audio_left_in  = 16'sd1000;
        audio_right_in = -16'sd1000;
        g_ll = 0; g_rl = 0; g_rr = 0; g_lr = 0;
        cur_l = 1000; cur_r = -1000;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_left", int'(audio_left_out), 0);
        chk("reset_right", int'(audio_right_out), 0);
        hold_check("muted", 1000, -1000);
        chk("muted_left_const", int'(audio_left_out), 0);

        send_frame(1'b1, 1'b0, 16'h080, 9);
        send_frame(1'b0, 1'b1, 16'h080, 9);
        hold_check("half", 1000, -1000);
        chk("half_left_const", int'(audio_left_out), 500);
        chk("half_right_const", int'(audio_right_out), -500);

        // Two-clock latency from input change to output
        audio_left_in = 16'sd2000;
        cur_l = 2000;
        tick();
        chk("lat1_left", int'(audio_left_out), 500);
        tick();
        chk("lat2_left", int'(audio_left_out), 1000);

        send_frame(1'b1, 1'b0, 16'h0FF, 9);
        send_frame(1'b1, 1'b0, 16'h1FF, 9);
        hold_check("sat_pos", 32767, 32767);
        chk("sat_pos_left_const", int'(audio_left_out), CROSS ? 32767 : 32639);
        hold_check("sat_neg", -32768, -32768);
        chk("sat_neg_left_const", int'(audio_left_out), CROSS ? -32768 : -32640);

        send_frame(1'b1, 1'b0, 16'h000, 5);
        hold_check("short5", 1000, 0);
        chk("short5_left_const", int'(audio_left_out), 996);
        send_frame(1'b1, 1'b0, 16'h640, 11);
        hold_check("long11", 1000, 0);
        chk("long11_left_const", int'(audio_left_out), 250);

        send_frame(1'b1, 1'b1, 16'h140, 9);
        hold_check("both_cs", 0, 4000);
        chk("both_cs_left_const", int'(audio_left_out), CROSS ? 1000 : 0);

        // Reset after four bits of a frame
        csdac1n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            datadac = 1'b1;
            clkdac  = 1'b1;
            tick();
            clkdac  = 1'b0;
            tick();
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        g_ll = 0; g_rl = 0; g_rr = 0; g_lr = 0;
        chk("midrst_left", int'(audio_left_out), 0);
        csdac1n = 1'b1;
        tick();
        tick();
        hold_check("midrst_muted", 1000, 1000);
        send_frame(1'b1, 1'b0, 16'h080, 9);
        hold_check("post_rst", 1000, 1000);
        chk("post_rst_right_const", int'(audio_right_out), 0);

        for (int k = 0; k < 24; k++) begin
            c1   = 1'($urandom_range(0, 1));
            c2   = (k % 5 == 0) ? 1'b1 : ~c1;
            bits = 16'($urandom);
            n    = (k % 4 == 3) ? int'($urandom_range(4, 8)) : int'($urandom_range(9, 13));
            send_frame(c1, c2, bits, n);
            l = int'($urandom_range(0, 65535)) - 32768;
            r = int'($urandom_range(0, 65535)) - 32768;
            hold_check("rand", l, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
